// File: rtl/led_chaser_if.sv
// Control/status bundle between an LED pattern consumer and the led_chaser generator.
// The master drives pattern controls; the slave (the chaser) returns the LED pattern and step pulse.
interface led_chaser_if #(
  parameter int unsigned N_LEDS = 4
) ();
  logic              en;
  logic              dir;
  logic [1:0]        mode;
  logic [N_LEDS-1:0] leds;
  logic              tick;

  modport master (
    output en,
    output dir,
    output mode,
    input  leds,
    input  tick
  );

  modport slave (
    input  en,
    input  dir,
    input  mode,
    output leds,
    output tick
  );
endinterface

// File: rtl/led_chaser.sv
// LED pattern generator: rotate, bounce, fill and blink patterns advanced on a prescaled tick.
// All outputs are registered; a mode change reloads the pattern and restarts the prescaler.
module led_chaser #(
  parameter int unsigned N_LEDS = 4,
  parameter int unsigned DIV    = 25000000
) (
  input  logic         clk,
  input  logic         rst,
  led_chaser_if.slave  bus
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [N_LEDS-1:0] LsbOne  = N_LEDS'(1);
  localparam logic [N_LEDS-1:0] MsbOne  = N_LEDS'(1) << (N_LEDS - 1);
  localparam logic [N_LEDS-1:0] AllOnes = {N_LEDS{1'b1}};

  typedef enum logic [1:0] {
    ModeRotate = 2'd0,
    ModeBounce = 2'd1,
    ModeFill   = 2'd2,
    ModeBlink  = 2'd3
  } mode_e;

  logic [CntW-1:0]   cnt_q, cnt_d;
  mode_e             mode_q, mode_d;
  logic              bdir_q, bdir_d;
  logic [N_LEDS-1:0] leds_q, leds_d;
  logic              tick_q, tick_d;

  logic              mode_chg;
  logic              wrap;
  logic [N_LEDS-1:0] rot_l, rot_r, shl, shr, fill_l, fill_r;
  logic [N_LEDS-1:0] init_pat, next_pat;
  logic              next_bdir;

  assign mode_chg = (bus.mode != mode_q);
  assign wrap     = (cnt_q == CntW'(DIV - 1));

  assign rot_l  = {leds_q[N_LEDS-2:0], leds_q[N_LEDS-1]};
  assign rot_r  = {leds_q[0], leds_q[N_LEDS-1:1]};
  assign shl    = {leds_q[N_LEDS-2:0], 1'b0};
  assign shr    = {1'b0, leds_q[N_LEDS-1:1]};
  assign fill_l = {leds_q[N_LEDS-2:0], 1'b1};
  assign fill_r = {1'b1, leds_q[N_LEDS-1:1]};

  always_comb begin
    init_pat = '0;
    if (mode_e'(bus.mode) == ModeRotate || mode_e'(bus.mode) == ModeBounce) begin
      init_pat = bus.dir ? MsbOne : LsbOne;
    end
  end

  // Pattern for the next step; bounce reverses at the end LED with no dwell.
  always_comb begin
    next_pat  = leds_q;
    next_bdir = bdir_q;
    unique case (mode_q)
      ModeRotate: next_pat = bus.dir ? rot_r : rot_l;
      ModeBounce: begin
        if (!bdir_q) begin
          if (leds_q[N_LEDS-1]) begin
            next_pat  = shr;
            next_bdir = 1'b1;
          end else begin
            next_pat  = shl;
          end
        end else begin
          if (leds_q[0]) begin
            next_pat  = shl;
            next_bdir = 1'b0;
          end else begin
            next_pat  = shr;
          end
        end
      end
      ModeFill: begin
        if (leds_q == AllOnes) next_pat = '0;
        else                   next_pat = bus.dir ? fill_r : fill_l;
      end
      ModeBlink:  next_pat = ~leds_q;
      default:    next_pat = leds_q;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    mode_d = mode_q;
    bdir_d = bdir_q;
    leds_d = leds_q;
    tick_d = 1'b0;
    if (mode_chg) begin
      // Reload wins over a coinciding step, independent of en.
      mode_d = mode_e'(bus.mode);
      cnt_d  = '0;
      bdir_d = bus.dir;
      leds_d = init_pat;
    end else if (bus.en) begin
      if (wrap) begin
        cnt_d  = '0;
        leds_d = next_pat;
        bdir_d = next_bdir;
        tick_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      mode_q <= ModeRotate;
      bdir_q <= 1'b0;
      leds_q <= LsbOne;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      bdir_q <= bdir_d;
      leds_q <= leds_d;
      tick_q <= tick_d;
    end
  end

  assign bus.leds = leds_q;
  assign bus.tick = tick_q;

endmodule

// File: tb/tb_led_chaser.sv
// Self-checking bench for led_chaser: directed walk-through of each pattern plus randomized
// stimulus compared cycle by cycle against an integer-arithmetic reference model.
module tb_led_chaser;

  localparam int unsigned N   = 4;
  localparam int unsigned DIV = 4;
  localparam int          MASK = (1 << N) - 1;

  logic clk;
  logic rst;

  led_chaser_if #(.N_LEDS(N)) bus ();

  led_chaser #(
    .N_LEDS (N),
    .DIV    (DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // Reference model state: pattern as an integer, enabled edges since last step/reload.
  int m_leds;
  int m_phase;
  int m_mode;
  int m_bdir;
  int m_tick;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int next_pattern(input int v, input int mode, input int dir,
                                      inout int bdir);
    int r;
    r = v;
    case (mode)
      0: r = dir ? ((v >> 1) | ((v & 1) << (N - 1))) : (((v << 1) | (v >> (N - 1))) & MASK);
      1: begin
        if (bdir == 0) begin
          if (((v >> (N - 1)) & 1) == 1) begin r = v >> 1; bdir = 1; end
          else r = (v << 1) & MASK;
        end else begin
          if ((v & 1) == 1) begin r = (v << 1) & MASK; bdir = 0; end
          else r = v >> 1;
        end
      end
      2: r = (v == MASK) ? 0 : (dir ? ((v >> 1) | (1 << (N - 1))) : (((v << 1) | 1) & MASK));
      default: r = (~v) & MASK;
    endcase
    return r;
  endfunction

  task automatic model_edge();
    int md;
    int dr;
    md = int'(bus.mode);
    dr = int'(bus.dir);
    if (rst) begin
      m_leds = 1; m_phase = 0; m_mode = 0; m_bdir = 0; m_tick = 0;
    end else if (md != m_mode) begin
      m_mode  = md;
      m_phase = 0;
      m_bdir  = dr;
      m_tick  = 0;
      m_leds  = (md <= 1) ? (dr ? (1 << (N - 1)) : 1) : 0;
    end else if (bus.en) begin
      m_phase++;
      m_tick = 0;
      if (m_phase == DIV) begin
        m_phase = 0;
        m_tick  = 1;
        m_leds  = next_pattern(m_leds, m_mode, dr, m_bdir);
      end
    end else begin
      m_tick = 0;
    end
  endtask

  // One clock: advance model with pre-edge inputs, then compare #1 after the edge.
  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check_val("leds", 32'(bus.leds), 32'(m_leds));
    check_val("tick", 32'(bus.tick), 32'(m_tick));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  int exp_bnc[7];
  int exp_fl0[5];
  int exp_fl1[5];

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_bnc = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    exp_fl0 = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000};
    exp_fl1 = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0000};

    rst      = 1'b1;
    bus.en   = 1'b1;
    bus.dir  = 1'b0;
    bus.mode = 2'd0;
    cycles(2);
    check_val("rst_leds", 32'(bus.leds), 32'h1);
    check_val("rst_tick", 32'(bus.tick), 32'h0);
    rst = 1'b0;

    // Rotate left: steps at edges 4, 8, 12, 16.
    for (int e = 1; e <= 16; e++) begin
      cyc();
      check_val("rot_tick", 32'(bus.tick), 32'((e % 4) == 0));
      if (e % 4 == 0) check_val("rot_leds", 32'(bus.leds), 32'(1 << ((e / 4) % 4)));
    end

    // Direction change mid-count applies at next step without reload.
    cycles(2);
    bus.dir = 1'b1;
    cycles(2);
    check_val("rot_dir1", 32'(bus.leds), 32'b1000);
    cycles(4);
    check_val("rot_dir2", 32'(bus.leds), 32'b0100);

    // Bounce: dir toggles are ignored after entry.
    bus.dir  = 1'b0;
    bus.mode = 2'd1;
    cyc();
    check_val("bnc_load", 32'(bus.leds), 32'b0001);
    for (int s = 0; s < 7; s++) begin
      for (int c = 0; c < 4; c++) begin
        bus.dir = 1'($urandom_range(0, 1));
        cyc();
      end
      check_val("bnc_step", 32'(bus.leds), 32'(exp_bnc[s]));
    end

    // Fill toward MSB.
    bus.dir  = 1'b0;
    bus.mode = 2'd2;
    cyc();
    check_val("fill_load", 32'(bus.leds), 32'b0000);
    for (int s = 0; s < 5; s++) begin
      cycles(4);
      check_val("fill0_step", 32'(bus.leds), 32'(exp_fl0[s]));
    end

    // Fill toward LSB from a fresh reload (via blink).
    bus.mode = 2'd3;
    cyc();
    bus.dir  = 1'b1;
    bus.mode = 2'd2;
    cyc();
    check_val("fill1_load", 32'(bus.leds), 32'b0000);
    for (int s = 0; s < 5; s++) begin
      cycles(4);
      check_val("fill1_step", 32'(bus.leds), 32'(exp_fl1[s]));
    end

    // Pause with partial count preserved.
    bus.dir  = 1'b0;
    bus.mode = 2'd0;
    cyc();
    cycles(2);
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check_val("pause_leds", 32'(bus.leds), 32'b0001);
      check_val("pause_tick", 32'(bus.tick), 32'h0);
    end
    bus.en = 1'b1;
    cyc();
    check_val("resume_wait", 32'(bus.tick), 32'h0);
    cyc();
    check_val("resume_leds", 32'(bus.leds), 32'b0010);
    check_val("resume_tick", 32'(bus.tick), 32'h1);

    // Mode change on what would have been a step edge discards the step.
    cycles(3);
    bus.mode = 2'd3;
    cyc();
    check_val("blink_load", 32'(bus.leds), 32'b0000);
    check_val("blink_notick", 32'(bus.tick), 32'h0);
    cycles(4);
    check_val("blink_on", 32'(bus.leds), 32'b1111);
    cycles(4);
    check_val("blink_off", 32'(bus.leds), 32'b0000);

    // Reset mid-count.
    cycles(2);
    rst = 1'b1;
    cyc();
    check_val("mid_rst_leds", 32'(bus.leds), 32'b0001);
    check_val("mid_rst_tick", 32'(bus.tick), 32'h0);
    rst      = 1'b0;
    bus.mode = 2'd0;
    cycles(3);
    check_val("post_rst_wait", 32'(bus.leds), 32'b0001);
    cyc();
    check_val("post_rst_step", 32'(bus.leds), 32'b0010);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.en  = ($urandom_range(0, 9) != 0);
      bus.dir = ($urandom_range(0, 15) == 0) ? ~bus.dir : bus.dir;
      if ($urandom_range(0, 39) == 0) bus.mode = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
